// File: rtl/io_pattern_engine.sv
// io_pattern_engine: drives a selectable test pattern onto the upper WIDTH-4
// IO pads, with the low 4 pads used as control inputs (en, load, mode).
// Patterns are up-counter, down-counter, Galois LFSR and rotating one-hot.
// Optional macro IO_PATTERN_SYNC_EN adds a 2-flop synchroniser on io_in[3:0].
module io_pattern_engine #(
    parameter int               WIDTH     = 16,
    parameter int               PRESCALE  = 0,
    parameter logic [WIDTH-5:0] SEED      = (WIDTH-4)'(1),
    parameter logic [WIDTH-5:0] LFSR_TAPS = (WIDTH-4)'('hE08)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] io_in,
    output logic [WIDTH-1:0] io_out,
    output logic [WIDTH-1:0] io_oeb
);

    localparam int DW = WIDTH - 4;

    logic [DW-1:0]    state_q, state_d, step_val;
    logic [7:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] oeb_q;
    logic [3:0]       ctrl;
    logic             en, load;
    logic [1:0]       mode;

    // Upper pads are outputs only; their input values are never used.
    logic unused_pads;
    assign unused_pads = ^io_in[WIDTH-1:4];

`ifdef IO_PATTERN_SYNC_EN
    logic [3:0] sync1_q, sync2_q;

    // Two-flop synchroniser for the asynchronous control pins.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q <= 4'h0;
            sync2_q <= 4'h0;
        end else begin
            sync1_q <= io_in[3:0];
            sync2_q <= sync1_q;
        end
    end

    assign ctrl = sync2_q;
`else
    assign ctrl = io_in[3:0];
`endif

    assign en   = ctrl[0];
    assign load = ctrl[1];
    assign mode = ctrl[3:2];

    // Next pattern value for the selected mode; zero recovers from lockup.
    always_comb begin
        step_val = state_q;
        case (mode)
            2'd0: step_val = state_q + DW'(1);
            2'd1: step_val = state_q - DW'(1);
            2'd2: begin
                if (state_q == '0)
                    step_val = SEED;
                else if (state_q[0])
                    step_val = (state_q >> 1) ^ LFSR_TAPS;
                else
                    step_val = state_q >> 1;
            end
            default: begin
                if (state_q == '0)
                    step_val = DW'(1);
                else
                    step_val = {state_q[DW-2:0], state_q[DW-1]};
            end
        endcase
    end

    // Control priority: load, then prescaled step, then count, else hold.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (load) begin
            state_d = SEED;
            cnt_d   = 8'd0;
        end else if (en) begin
            if (cnt_q == 8'(PRESCALE)) begin
                state_d = step_val;
                cnt_d   = 8'd0;
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
        end
    end

    // State, prescale count and output-enable registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= '0;
            cnt_q   <= 8'd0;
            oeb_q   <= '1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            oeb_q   <= {{DW{1'b0}}, 4'hF};
        end
    end

    assign io_out = {state_q, 4'h0};
    assign io_oeb = oeb_q;

endmodule
